// File: rtl/pasr_ctrl.sv
// pasr_ctrl: command sequencer for an external N-bit parallel access shift register.
// Accepts TX/RX commands over a valid/ready handshake. TX loads a word into the
// PASR and streams it LSB-first on sdo with a bit-valid strobe; RX shifts N bits
// of sdi into the PASR and captures the parallel word into rx_data.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready          command handshake (ready only in IDLE)
//   cmd_mode, cmd_data           0 = TX with cmd_data, 1 = RX
//   abort                        synchronous cancel of the current operation
//   pasr_load/pasr_I/pasr_serial_in   drive to the PASR
//   pasr_q/pasr_serial_out       from the PASR
//   sdi                          serial data for RX
//   sdo, tx_bit_valid            transmitted bit and its strobe
//   rx_data                      last completed RX word
//   done, busy                   completion pulse, not-idle flag
`timescale 1ns/1ps
module pasr_ctrl #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_mode,
  input  logic [N-1:0] cmd_data,
  input  logic         abort,
  output logic         pasr_load,
  output logic [N-1:0] pasr_I,
  output logic         pasr_serial_in,
  input  logic [N-1:0] pasr_q,
  input  logic         pasr_serial_out,
  input  logic         sdi,
  output logic         sdo,
  output logic         tx_bit_valid,
  output logic [N-1:0] rx_data,
  output logic         done,
  output logic         busy
);

  localparam int unsigned CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_mode;
  logic [N-1:0]  r_data;
  logic [N-1:0]  r_rx_data;
  logic          r_cmd_ready;
  logic          r_pasr_load;
  logic          r_tx_bit_valid;
  logic          r_done;
  logic          r_busy;
  logic          w_rx_shift;

  // Sequencer; every output register is set to its value for the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_mode         <= 1'b0;
      r_data         <= '0;
      r_rx_data      <= '0;
      r_cmd_ready    <= 1'b1;
      r_pasr_load    <= 1'b0;
      r_tx_bit_valid <= 1'b0;
      r_done         <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_pasr_load    <= 1'b0;
      r_tx_bit_valid <= 1'b0;
      r_done         <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // abort outranks a pending command in IDLE
          if (cmd_valid && !abort) begin
            r_mode      <= cmd_mode;
            r_data      <= cmd_data;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (cmd_mode) begin
              r_state <= S_SHIFT;
            end else begin
              r_state     <= S_LOAD;
              r_pasr_load <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (abort) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_state        <= S_SHIFT;
            r_cnt          <= '0;
            r_tx_bit_valid <= 1'b1;
          end
        end
        S_SHIFT: begin
          if (abort) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end else if (r_cnt == CW'(N - 1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_cnt          <= r_cnt + CW'(1);
            r_tx_bit_valid <= ~r_mode;
          end
        end
        S_DONE: begin
          // PASR still holds the received word during DONE; it shifts away after this edge
          if (r_mode && !abort) begin
            r_rx_data <= pasr_q;
          end
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_cmd_ready <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // sdi passes straight through to the PASR only while receiving
  assign w_rx_shift     = (r_state == S_SHIFT) && r_mode;
  assign pasr_serial_in = w_rx_shift & sdi;
  assign sdo            = r_tx_bit_valid & pasr_serial_out;

  assign cmd_ready    = r_cmd_ready;
  assign pasr_load    = r_pasr_load;
  assign pasr_I       = r_data;
  assign tx_bit_valid = r_tx_bit_valid;
  assign rx_data      = r_rx_data;
  assign done         = r_done;
  assign busy         = r_busy;

endmodule
